// File: rtl/cnn_pkg.sv
// Shared definitions for the conv parameter feeder: header layout,
// capture-slot numbering and the fetch state machine encoding.
package cnn_pkg;

  localparam int HDR_BYTES    = 6;
  localparam int KERNEL_WORDS = 9;

  // Capture slots: 0..5 header bytes, 6 bias, 7..15 kernel words.
  localparam logic [3:0] HDR_LAST     = 4'd0;
  localparam logic [3:0] HDR_CHANNELS = 4'd1;
  localparam logic [3:0] HDR_KSIZE    = 4'd2;
  localparam logic [3:0] HDR_STRIDE   = 4'd3;
  localparam logic [3:0] HDR_IFSIZE   = 4'd4;
  localparam logic [3:0] HDR_FILTERS  = 4'd5;
  localparam logic [3:0] SEL_BIAS     = 4'd6;
  localparam logic [3:0] SEL_KERN0    = 4'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_BIAS,
    ST_KERN,
    ST_DRAIN,
    ST_COMMIT,
    ST_WAIT,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/conv_geom_calc.sv
// Derives the squared sizes, output size and output base address of a
// layer from its header fields. Purely combinational, mod 2^16.
module conv_geom_calc (
  input  logic [7:0]  kernel_size,
  input  logic [7:0]  stride,
  input  logic [7:0]  if_size,
  input  logic [7:0]  amount_channels,
  input  logic [15:0] in_off,
  output logic [7:0]  kernel_size_2,
  output logic [7:0]  of_size,
  output logic [15:0] ifsize_2,
  output logic [15:0] ofsize_2,
  output logic [15:0] of_offset
);

  logic [15:0] k16, if16, ks2_16, of16;

  // stride holds log2 of the step, so the division is a right shift.
  always_comb begin
    k16           = {8'd0, kernel_size};
    if16          = {8'd0, if_size};
    ks2_16        = k16 * k16;
    kernel_size_2 = ks2_16[7:0];
    ifsize_2      = if16 * if16;
    of16          = ((if16 - k16) >> stride) + 16'd1;
    of_size       = of16[7:0];
    ofsize_2      = {8'd0, of_size} * {8'd0, of_size};
    of_offset     = in_off + ifsize_2 * {8'd0, amount_channels};
  end

endmodule

// File: rtl/conv_param_feeder.sv
// Fetches layer headers, biases and kernels from weight memory into shadow
// registers and publishes them as one bundle with a struct_ready pulse.
module conv_param_feeder
  import cnn_pkg::*;
#(
  parameter int ADDRESS_BITS = 12,
  parameter int BASE_ADDR    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    next,
  input  logic                    next_filter,
  input  logic                    next_channel,
  output logic                    wmem_rd,
  output logic [ADDRESS_BITS-1:0] wmem_addr,
  input  logic [7:0]              wmem_data,
  output logic [7:0]              last_stage,
  output logic [7:0]              amount_channels,
  output logic [7:0]              kernel_size,
  output logic [7:0]              stride,
  output logic [7:0]              if_size,
  output logic [7:0]              amount_filters,
  output logic [7:0]              kernel_size_2,
  output logic [7:0]              of_size,
  output logic [15:0]             ifsize_2,
  output logic [15:0]             ofsize_2,
  output logic [15:0]             of_offset,
  output logic [7:0]              kernel [0:8],
  output logic [7:0]              bias,
  output logic                    struct_ready,
  output logic                    done,
  output logic                    protocol_err
);

  feeder_state_t state;
  logic [ADDRESS_BITS-1:0] ptr, layer_base;
  logic [15:0] in_off;
  logic [7:0]  filter, channel;
  logic [3:0]  cnt, cap_sel;
  logic        cap_valid;
  logic [7:0]  sh_hdr [0:HDR_BYTES-1];
  logic [7:0]  sh_bias;
  logic [7:0]  sh_kern [0:KERNEL_WORDS-1];

  logic [7:0]  g_ks2, g_of;
  logic [15:0] g_ifs2, g_ofs2, g_off;
  logic [31:0] filter_len, layer_end32, next_filter32;
  logic        any_req, can_accept;

  conv_geom_calc u_geom (
    .kernel_size     (sh_hdr[HDR_KSIZE]),
    .stride          (sh_hdr[HDR_STRIDE]),
    .if_size         (sh_hdr[HDR_IFSIZE]),
    .amount_channels (sh_hdr[HDR_CHANNELS]),
    .in_off          (in_off),
    .kernel_size_2   (g_ks2),
    .of_size         (g_of),
    .ifsize_2        (g_ifs2),
    .ofsize_2        (g_ofs2),
    .of_offset       (g_off)
  );

  // Jump targets let next/next_filter skip any channels that were never requested.
  always_comb begin
    filter_len    = 32'd1 + 32'(amount_channels) * KERNEL_WORDS;
    layer_end32   = 32'(layer_base) + HDR_BYTES + 32'(amount_filters) * filter_len;
    next_filter32 = 32'(layer_base) + HDR_BYTES + (32'(filter) + 32'd1) * filter_len;
    any_req       = next | next_filter | next_channel;
    can_accept    = (state == ST_WAIT) && !struct_ready;
    wmem_rd       = (state == ST_HDR) || (state == ST_BIAS) || (state == ST_KERN);
    wmem_addr     = ptr;
  end

  // Read data arrives one cycle after the strobe; cap_sel remembers its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HDR_BYTES; i++) sh_hdr[i] <= 8'd0;
      for (int i = 0; i < KERNEL_WORDS; i++) sh_kern[i] <= 8'd0;
      sh_bias <= 8'd0;
    end else if (cap_valid) begin
      if (cap_sel < SEL_BIAS) sh_hdr[cap_sel[2:0]] <= wmem_data;
      else if (cap_sel == SEL_BIAS) sh_bias <= wmem_data;
      else sh_kern[cap_sel - SEL_KERN0] <= wmem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      layer_base      <= '0;
      in_off          <= 16'd0;
      filter          <= 8'd0;
      channel         <= 8'd0;
      cnt             <= 4'd0;
      cap_sel         <= 4'd0;
      cap_valid       <= 1'b0;
      last_stage      <= 8'd0;
      amount_channels <= 8'd0;
      kernel_size     <= 8'd0;
      stride          <= 8'd0;
      if_size         <= 8'd0;
      amount_filters  <= 8'd0;
      kernel_size_2   <= 8'd0;
      of_size         <= 8'd0;
      ifsize_2        <= 16'd0;
      ofsize_2        <= 16'd0;
      of_offset       <= 16'd0;
      for (int i = 0; i < KERNEL_WORDS; i++) kernel[i] <= 8'd0;
      bias            <= 8'd0;
      struct_ready    <= 1'b0;
      done            <= 1'b0;
      protocol_err    <= 1'b0;
    end else begin
      struct_ready <= 1'b0;
      cap_valid    <= 1'b0;
      if (any_req && !can_accept) protocol_err <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ptr        <= ADDRESS_BITS'(BASE_ADDR);
            layer_base <= ADDRESS_BITS'(BASE_ADDR);
            in_off     <= 16'd0;
            filter     <= 8'd0;
            channel    <= 8'd0;
            cnt        <= 4'd0;
            done       <= 1'b0;
            state      <= ST_HDR;
          end
        end
        ST_HDR: begin
          cap_valid <= 1'b1;
          cap_sel   <= cnt;
          ptr       <= ptr + 1'b1;
          if (cnt == 4'(HDR_BYTES - 1)) begin
            cnt   <= 4'd0;
            state <= ST_BIAS;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_BIAS: begin
          cap_valid <= 1'b1;
          cap_sel   <= SEL_BIAS;
          ptr       <= ptr + 1'b1;
          cnt       <= 4'd0;
          state     <= ST_KERN;
        end
        ST_KERN: begin
          cap_valid <= 1'b1;
          cap_sel   <= SEL_KERN0 + cnt;
          ptr       <= ptr + 1'b1;
          if (cnt == 4'(KERNEL_WORDS - 1)) begin
            cnt   <= 4'd0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DRAIN: state <= ST_COMMIT;
        ST_COMMIT: begin
          last_stage      <= sh_hdr[HDR_LAST];
          amount_channels <= sh_hdr[HDR_CHANNELS];
          kernel_size     <= sh_hdr[HDR_KSIZE];
          stride          <= sh_hdr[HDR_STRIDE];
          if_size         <= sh_hdr[HDR_IFSIZE];
          amount_filters  <= sh_hdr[HDR_FILTERS];
          kernel_size_2   <= g_ks2;
          of_size         <= g_of;
          ifsize_2        <= g_ifs2;
          ofsize_2        <= g_ofs2;
          of_offset       <= g_off;
          for (int i = 0; i < KERNEL_WORDS; i++) kernel[i] <= sh_kern[i];
          bias            <= sh_bias;
          struct_ready    <= 1'b1;
          state           <= ST_WAIT;
        end
        ST_WAIT: begin
          if (can_accept) begin
            if (next) begin
              if (last_stage[0]) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                ptr        <= layer_end32[ADDRESS_BITS-1:0];
                layer_base <= layer_end32[ADDRESS_BITS-1:0];
                in_off     <= of_offset;
                filter     <= 8'd0;
                channel    <= 8'd0;
                cnt        <= 4'd0;
                state      <= ST_HDR;
              end
            end else if (next_filter) begin
              if (filter == amount_filters - 8'd1) begin
                protocol_err <= 1'b1;
              end else begin
                ptr     <= next_filter32[ADDRESS_BITS-1:0];
                filter  <= filter + 8'd1;
                channel <= 8'd0;
                state   <= ST_BIAS;
              end
            end else if (next_channel) begin
              if (channel == amount_channels - 8'd1) begin
                protocol_err <= 1'b1;
              end else begin
                channel <= channel + 8'd1;
                cnt     <= 4'd0;
                state   <= ST_KERN;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_param_feeder.sv
// Directed bench for conv_param_feeder: a two-layer network in a byte
// memory model, request latencies, fetched fields, errors and reset.
module tb_conv_param_feeder;

  logic        clk = 1'b0;
  logic        rst, start, next, next_filter, next_channel;
  logic        wmem_rd;
  logic [11:0] wmem_addr;
  logic [7:0]  wmem_data;
  logic [7:0]  last_stage, amount_channels, kernel_size, stride, if_size;
  logic [7:0]  amount_filters, kernel_size_2, of_size, bias;
  logic [15:0] ifsize_2, ofsize_2, of_offset;
  logic [7:0]  kernel [0:8];
  logic        struct_ready, done, protocol_err;

  int checks = 0;
  int passed = 0;
  int lat;
  bit stable;

  logic [7:0]  mem [0:4095];
  int          rd_count;
  logic [11:0] first_addr, last_addr;
  bit          contiguous;

  conv_param_feeder #(.ADDRESS_BITS(12), .BASE_ADDR(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .next            (next),
    .next_filter     (next_filter),
    .next_channel    (next_channel),
    .wmem_rd         (wmem_rd),
    .wmem_addr       (wmem_addr),
    .wmem_data       (wmem_data),
    .last_stage      (last_stage),
    .amount_channels (amount_channels),
    .kernel_size     (kernel_size),
    .stride          (stride),
    .if_size         (if_size),
    .amount_filters  (amount_filters),
    .kernel_size_2   (kernel_size_2),
    .of_size         (of_size),
    .ifsize_2        (ifsize_2),
    .ofsize_2        (ofsize_2),
    .of_offset       (of_offset),
    .kernel          (kernel),
    .bias            (bias),
    .struct_ready    (struct_ready),
    .done            (done),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wmem_rd) wmem_data <= mem[wmem_addr];

  // Read monitor: count strobes and track first/last address and contiguity.
  always @(posedge clk) begin
    if (wmem_rd) begin
      if (rd_count == 0) first_addr <= wmem_addr;
      else if (wmem_addr != last_addr + 12'd1) contiguous <= 1'b0;
      last_addr <= wmem_addr;
      rd_count  <= rd_count + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input int which, input logic val);
    case (which)
      0: start = val;
      1: next = val;
      2: next_filter = val;
      3: next_channel = val;
      default: ;
    endcase
  endtask

  // Pulses one request, optionally injects a second one mid-fetch, and
  // reports the pulse latency (0 = none within 40 cycles) and output stability.
  task automatic apply_stimulus(input int which, input int inject_at, input int inject_which,
                                output int latency, output bit steady);
    logic [7:0] b0, k0;
    @(negedge clk);
    drive(which, 1'b1);
    @(posedge clk);
    #1;
    drive(which, 1'b0);
    rd_count   = 0;
    contiguous = 1'b1;
    b0         = bias;
    k0         = kernel[0];
    steady     = 1'b1;
    latency    = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == inject_at) drive(inject_which, 1'b1);
      @(posedge clk);
      #1;
      if (i == inject_at) drive(inject_which, 1'b0);
      if (struct_ready && latency == 0) latency = i;
      if (latency == 0 && (bias !== b0 || kernel[0] !== k0)) steady = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    mem[0] = 8'd0; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd0; mem[4] = 8'd12; mem[5] = 8'd2;
    mem[6] = 8'd5;
    mem[25] = 8'd7;
    mem[44] = 8'd1; mem[45] = 8'd2; mem[46] = 8'd3; mem[47] = 8'd1; mem[48] = 8'd10; mem[49] = 8'd1;
    mem[50] = 8'd9;
    for (int i = 0; i < 9; i++) begin
      mem[7 + i]  = 8'(1 + i);
      mem[16 + i] = 8'(11 + i);
      mem[26 + i] = 8'(21 + i);
      mem[35 + i] = 8'(31 + i);
      mem[51 + i] = 8'(41 + i);
      mem[60 + i] = 8'(51 + i);
    end
    rst = 1'b1; start = 1'b0; next = 1'b0; next_filter = 1'b0; next_channel = 1'b0;
    rd_count = 0; contiguous = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_struct_ready", struct_ready, 0);
    check_output("reset_done", done, 0);
    check_output("reset_err", protocol_err, 0);
    check_output("reset_rd", wmem_rd, 0);
    check_output("reset_bias", bias, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] layer 0 start");
    apply_stimulus(0, 0, 0, lat, stable);
    check_output("start_latency", lat, 18);
    check_output("start_reads", rd_count, 16);
    check_output("start_first_addr", first_addr, 0);
    check_output("start_last_addr", last_addr, 15);
    check_output("start_contiguous", contiguous, 1);
    check_output("l0_of_size", of_size, 10);
    check_output("l0_ofsize_2", ofsize_2, 100);
    check_output("l0_kernel_size_2", kernel_size_2, 9);
    check_output("l0_ifsize_2", ifsize_2, 144);
    check_output("l0_of_offset", of_offset, 288);
    check_output("l0_channels", amount_channels, 2);
    check_output("l0_if_size", if_size, 12);
    check_output("l0_kernel0", kernel[0], 1);
    check_output("l0_kernel4", kernel[4], 5);
    check_output("l0_kernel8", kernel[8], 9);
    check_output("l0_bias", bias, 5);

    $display("[TB] next_channel");
    apply_stimulus(3, 0, 0, lat, stable);
    check_output("nc_latency", lat, 11);
    check_output("nc_reads", rd_count, 9);
    check_output("nc_first_addr", first_addr, 16);
    check_output("nc_last_addr", last_addr, 24);
    check_output("nc_bias", bias, 5);
    check_output("nc_kernel0", kernel[0], 11);
    check_output("nc_kernel8", kernel[8], 19);

    $display("[TB] next_filter");
    apply_stimulus(2, 0, 0, lat, stable);
    check_output("nf_latency", lat, 12);
    check_output("nf_reads", rd_count, 10);
    check_output("nf_first_addr", first_addr, 25);
    check_output("nf_last_addr", last_addr, 34);
    check_output("nf_stable", stable, 1);
    check_output("nf_bias", bias, 7);
    check_output("nf_kernel0", kernel[0], 21);

    apply_stimulus(3, 0, 0, lat, stable);
    check_output("nc2_first_addr", first_addr, 35);
    check_output("nc2_kernel0", kernel[0], 31);
    check_output("err_clear_before", protocol_err, 0);

    $display("[TB] next_channel on last channel");
    apply_stimulus(3, 0, 0, lat, stable);
    check_output("nc_last_err", protocol_err, 1);
    check_output("nc_last_reads", rd_count, 0);
    check_output("nc_last_no_pulse", lat, 0);
    check_output("nc_last_kernel0", kernel[0], 31);

    $display("[TB] next to layer 1");
    apply_stimulus(1, 0, 0, lat, stable);
    check_output("n_latency", lat, 18);
    check_output("n_first_addr", first_addr, 44);
    check_output("n_last_addr", last_addr, 59);
    check_output("l1_last_stage", last_stage, 1);
    check_output("l1_of_size", of_size, 4);
    check_output("l1_ofsize_2", ofsize_2, 16);
    check_output("l1_ifsize_2", ifsize_2, 100);
    check_output("l1_of_offset", of_offset, 488);
    check_output("l1_bias", bias, 9);
    check_output("l1_kernel0", kernel[0], 41);

    $display("[TB] next on last stage");
    apply_stimulus(1, 0, 0, lat, stable);
    check_output("last_done", done, 1);
    check_output("last_no_pulse", lat, 0);
    check_output("last_reads", rd_count, 0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst2_done", done, 0);
    check_output("rst2_err", protocol_err, 0);

    $display("[TB] next_filter during KERN");
    apply_stimulus(0, 10, 2, lat, stable);
    check_output("kern_nf_err", protocol_err, 1);
    check_output("kern_nf_latency", lat, 18);
    check_output("kern_nf_bias", bias, 5);
    check_output("kern_nf_kernel0", kernel[0], 1);
    apply_stimulus(2, 0, 0, lat, stable);
    check_output("after_err_nf_first", first_addr, 25);
    check_output("after_err_nf_bias", bias, 7);

    $display("[TB] reset mid-KERN");
    @(negedge clk);
    next_channel = 1'b1;
    @(posedge clk);
    #1;
    next_channel = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output("arst_bias", bias, 0);
    check_output("arst_kernel0", kernel[0], 0);
    check_output("arst_of_offset", of_offset, 0);
    check_output("arst_rd", wmem_rd, 0);
    check_output("arst_addr", wmem_addr, 0);
    check_output("arst_err", protocol_err, 0);
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus(0, 0, 0, lat, stable);
    check_output("restart_latency", lat, 18);
    check_output("restart_first_addr", first_addr, 0);
    check_output("restart_of_offset", of_offset, 288);
    check_output("restart_kernel8", kernel[8], 9);
    check_output("restart_bias", bias, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/conv_param_feeder.md
# conv_param_feeder

Responder side of the conv controller's structure handshake. It fetches layer descriptors, biases and 3x3 kernels byte-by-byte from the weight memory and derives the geometry fields. It presents them as one stable bundle with a 1-cycle `struct_ready` pulse whenever the controller requests `next`, `next_filter` or `next_channel`. It sits between the weight memory and `fsm_rn`.

## Interface
- `ADDRESS_BITS`, 12: weight-memory address width.
- `BASE_ADDR`, 0: address of the layer-0 descriptor.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin the network at `BASE_ADDR`.
- `next`, `next_filter`, `next_channel` in 1 each: request pulses from the controller.
- `wmem_rd` out 1: read strobe.
- `wmem_addr` out ADDRESS_BITS: read address.
- `wmem_data` in 8: read data, valid 1 cycle after `wmem_rd`.
- `last_stage`, `amount_channels`, `kernel_size`, `stride`, `if_size`, `amount_filters`, `kernel_size_2`, `of_size` out 8 each: layer fields.
- `ifsize_2`, `ofsize_2`, `of_offset` out 16 each: derived sizes and the output base address.
- `kernel[0:8]` out 8 each: weights, row-major.
- `bias` out 8: current filter bias.
- `struct_ready` out 1: 1-cycle pulse; the bundle is valid from this cycle on.
- `done` out 1: sticky; set after `next` on the last stage.
- `protocol_err` out 1: sticky illegal-request flag.

## Operation
- Memory layout per layer:
  - 6-byte header: `last_stage`(bit0), `amount_channels`, `kernel_size`, `stride`, `if_size`, `amount_filters`.
  - Then for each filter: 1 bias byte followed by `amount_channels`×9 kernel bytes.
  - The next layer's header follows immediately.
- States:
  - IDLE: waits for `start`.
  - HDR: 6 reads.
  - BIAS: 1 read.
  - KERN: 9 reads.
  - COMMIT: `struct_ready`=1.
  - WAIT: accepts requests.
  - DONE.
- Transitions:
  - start (IDLE/DONE) → HDR, with ptr=`BASE_ADDR`, in_off=0, filter=0, channel=0, `done` cleared.
  - next → HDR if `last_stage`=0; otherwise → DONE with `done`=1 and no pulse.
  - next_filter → BIAS, with filter+1, channel=0.
  - next_channel → KERN, with channel+1.
- Request priority in WAIT: next > next_filter > next_channel.
- Fetched bytes land in shadow registers. All outputs update together only on entry to COMMIT, so outputs stay stable during fetches.
- Derived fields at commit:
  - `kernel_size_2`=k·k (8 bit).
  - `ifsize_2`=if·if.
  - `of_size`=((if−k)>>stride)+1, where `stride` is log2 of the stride.
  - `ofsize_2`=of·of.
  - `of_offset`=in_off+`ifsize_2`·`amount_channels`.
  - All arithmetic is mod 2^16.
- On a `next` fetch, in_off takes the previous `of_offset`.
- `protocol_err` is set (and the request ignored) on:
  - any request outside WAIT;
  - `next_channel` when channel = `amount_channels`−1;
  - `next_filter` when filter = `amount_filters`−1.
- `start` outside IDLE/DONE is ignored and does not set the error.
- `wmem_addr` wraps modulo 2^ADDRESS_BITS.

## Timing
- Reads issue on consecutive cycles with contiguous addresses, no bubbles.
- For R bytes fetched, `struct_ready` is high exactly R+2 cycles after the accepting edge: R read cycles, +1 for the last data, +1 for commit.
- R values:
  - start / next: 16.
  - next_filter: 10.
  - next_channel: 9.
- A request is accepted earliest in the cycle after `struct_ready`.
- Reset, asynchronous at any time including mid-fetch: all outputs 0, state IDLE, pointers and counters 0.

## Structure
- Shared package `cnn_pkg` holds:
  - `HDR_BYTES`=6, `KERNEL_WORDS`=9;
  - header byte offsets;
  - the state enum.
- One sub-module, `conv_geom_calc`, computes the derived fields from the shadow header and in_off.

## Test plan
- Layer-0 start with header {0,2,3,0,12,2}, bias 5, kernel bytes 1..9:
  - pulse at edge+18;
  - `of_size`=10, `ofsize_2`=100, `kernel_size_2`=9, `ifsize_2`=144, `of_offset`=288;
  - `kernel`=1..9, `bias`=5.
- `next_channel` in WAIT:
  - addresses 16..24 read, pulse after 11 cycles;
  - `bias` unchanged, new kernel loaded.
- `next_filter`:
  - reads at 25..34, pulse after 12 cycles;
  - `kernel` and `bias` do not change before the pulse.
- Second layer, header {1,2,3,1,10,1}:
  - `of_size`=4, in_off=288, `of_offset`=488.
  - A following `next` sets `done`, with no pulse.
- Error cases:
  - `next_channel` at channel 1 of 2 → `protocol_err`=1, no reads.
  - `next_filter` during KERN → `protocol_err`=1, no effect.
- Reset asserted mid-KERN → all outputs 0 immediately. A fresh `start` then reproduces the first scenario.
